// File: rtl/pattern_seq_gen_if.sv
// Pattern sequencer bus: table write port, playback control and the output stream.
// The controller drives through the master modport; the sequencer sits on the slave.
interface pattern_seq_gen_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
);
  logic          i_wr_en;
  logic [AW-1:0] i_addr;
  logic [DW:0]   i_data;
  logic          i_start;
  logic          i_stop;
  logic [AW-1:0] i_len;
  logic          i_loop;
  logic          o_dv;
  logic [DW-1:0] o_data;
  logic          o_busy;
  logic          o_wrap;

  modport master (
    output i_wr_en, i_addr, i_data, i_start, i_stop, i_len, i_loop,
    input  o_dv, o_data, o_busy, o_wrap
  );

  modport slave (
    input  i_wr_en, i_addr, i_data, i_start, i_stop, i_len, i_loop,
    output o_dv, o_data, o_busy, o_wrap
  );
endinterface

// File: rtl/pattern_seq_gen.sv
// Programmable pattern sequencer: plays a DEPTH-entry {valid, data} table, one entry per
// clock, in one-shot or loop mode. The table is written at runtime and reads are
// read-before-write. All outputs are registered.
// Optional build macro SEQ_DOWN_COUNT_EN: play entries from len down to 0 instead of 0 up to len.
module pattern_seq_gen #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input logic               sclk,
  input logic               rst_n,
  pattern_seq_gen_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] len_q, len_d;
  logic          loop_q, loop_d;
  logic          dv_q, dv_d;
  logic [DW-1:0] data_q, data_d;
  logic          busy_q, busy_d;
  logic          wrap_q, wrap_d;

  logic [DW:0]   tbl_q [DEPTH];
  logic [DW:0]   rd_word;

  logic          pass_end;
  logic [AW-1:0] idx_start;
  logic [AW-1:0] idx_reload;
  logic [AW-1:0] idx_step;

`ifdef SEQ_DOWN_COUNT_EN
  assign idx_start  = bus.i_len;
  assign idx_reload = len_q;
  assign idx_step   = idx_q - 1'b1;
  assign pass_end   = (idx_q == '0);
`else
  assign idx_start  = '0;
  assign idx_reload = '0;
  assign idx_step   = idx_q + 1'b1;
  assign pass_end   = (idx_q == len_q);
`endif

  // Old contents are read on a same-address write edge since the table updates with <=.
  assign rd_word = tbl_q[idx_q];

  // Pattern table storage, cleared by reset, writable in any state.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (bus.i_wr_en) begin
      tbl_q[bus.i_addr] <= bus.i_data;
    end
  end

  // FSM next state, playback index and registered output values.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    loop_d  = loop_q;
    dv_d    = 1'b0;
    data_d  = '0;
    busy_d  = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.i_start && !bus.i_stop) begin
          state_d = StRun;
          len_d   = bus.i_len;
          loop_d  = bus.i_loop;
          idx_d   = idx_start;
          busy_d  = 1'b1;
        end
      end
      StRun: begin
        // Stop outranks the end-of-pass handling.
        if (bus.i_stop) begin
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          busy_d = 1'b1;
          dv_d   = rd_word[DW];
          data_d = rd_word[DW-1:0];
          wrap_d = pass_end;
          if (pass_end) begin
            idx_d = idx_reload;
            if (!loop_q) begin
              state_d = StIdle;
            end
          end else begin
            idx_d = idx_step;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      dv_q    <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      dv_q    <= dv_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.o_dv   = dv_q;
  assign bus.o_data = data_q;
  assign bus.o_busy = busy_q;
  assign bus.o_wrap = wrap_q;

endmodule

// File: tb/tb_pattern_seq_gen.sv
// Directed bench for pattern_seq_gen with a scoreboard of expected {busy, wrap, dv, data}.
module tb_pattern_seq_gen;

  logic sclk  = 1'b0;
  logic rst_n = 1'b0;

  always #5 sclk = ~sclk;

  pattern_seq_gen_if #(.DW(8), .AW(3)) bus ();

  pattern_seq_gen #(.DW(8), .DEPTH(8), .AW(3)) dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [10:0] exp_q [$];
  logic [8:0]  mtab [8];
  int          n_cmp = 0;
  int          n_err = 0;
  string       tag   = "";

  function automatic int pidx(input int pos, input int len);
`ifdef SEQ_DOWN_COUNT_EN
    return len - pos;
`else
    return pos;
`endif
  endfunction

  task automatic push(input logic busy, input logic wrap, input logic dv, input logic [7:0] d);
    exp_q.push_back({busy, wrap, dv, d});
  endtask

  task automatic pop_cmp();
    logic [10:0] ob;
    logic [10:0] ex;
    ob = {bus.o_busy, bus.o_wrap, bus.o_dv, bus.o_data};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, ob);
    end else begin
      ex = exp_q.pop_front();
      assert (ob === ex) else begin
        n_err++;
        $error("FAIL %s: observed busy/wrap/dv/data=%h expected %h", tag, ob, ex);
      end
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
    pop_cmp();
  endtask

  task automatic idle_tick();
    push(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
  endtask

  task automatic wr(input int a, input logic [8:0] w);
    bus.i_wr_en = 1'b1;
    bus.i_addr  = 3'(a);
    bus.i_data  = w;
    idle_tick();
    bus.i_wr_en = 1'b0;
    mtab[a] = w;
  endtask

  task automatic start(input int len, input logic loop);
    bus.i_start = 1'b1;
    bus.i_len   = 3'(len);
    bus.i_loop  = loop;
    push(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic play_pos(input int pos, input int len);
    logic [8:0] w;
    w = mtab[pidx(pos, len)];
    push(1'b1, pos == len, w[8], w[7:0]);
    tick();
  endtask

  task automatic play_pass(input int len);
    for (int p = 0; p <= len; p++) begin
      play_pos(p, len);
    end
  endtask

  initial begin
    logic [8:0] w;
    for (int i = 0; i < 8; i++) mtab[i] = '0;
    bus.i_wr_en = 1'b0;
    bus.i_addr  = '0;
    bus.i_data  = '0;
    bus.i_start = 1'b0;
    bus.i_stop  = 1'b0;
    bus.i_len   = '0;
    bus.i_loop  = 1'b0;

    tag = "reset";
    #2;
    push(1'b0, 1'b0, 1'b0, 8'h00);
    pop_cmp();
    idle_tick();
    @(negedge sclk);
    rst_n = 1'b1;

    tag = "write";
    wr(0, 9'h107);
    wr(1, 9'h000);
    wr(2, 9'h105);

    tag = "oneshot";
    start(2, 1'b0);
    play_pass(2);
    idle_tick();
    idle_tick();

    tag = "loop";
    start(2, 1'b1);
    // Changes during RUN must not affect the current run.
    bus.i_len  = 3'd0;
    bus.i_loop = 1'b0;
    play_pass(2);
    play_pass(2);
    play_pass(2);

    tag = "stop";
    play_pos(0, 2);
    play_pos(1, 2);
    bus.i_stop = 1'b1;
    idle_tick();
    tag = "start_and_stop";
    bus.i_start = 1'b1;
    idle_tick();
    bus.i_start = 1'b0;
    bus.i_stop  = 1'b0;
    idle_tick();

    tag = "rbw";
    start(7, 1'b1);
    for (int p = 0; p <= 7; p++) begin
      if (pidx(p, 7) == 4) begin
        bus.i_wr_en = 1'b1;
        bus.i_addr  = 3'd4;
        bus.i_data  = 9'h1AA;
        play_pos(p, 7);
        bus.i_wr_en = 1'b0;
        mtab[4] = 9'h1AA;
      end else begin
        play_pos(p, 7);
      end
    end
    tag = "rbw_next_pass";
    play_pass(7);
    bus.i_stop = 1'b1;
    idle_tick();
    bus.i_stop = 1'b0;

    tag = "async_reset";
    start(2, 1'b0);
    play_pos(0, 2);
    #2;
    rst_n = 1'b0;
    #1;
    push(1'b0, 1'b0, 1'b0, 8'h00);
    pop_cmp();
    for (int i = 0; i < 8; i++) mtab[i] = '0;
    idle_tick();
    @(negedge sclk);
    rst_n = 1'b1;
    tag = "after_reset";
    start(2, 1'b0);
    play_pass(2);
    idle_tick();

    tag = "drain";
    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL %s: observed %0d pending expected 0", tag, exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
